// File: rtl/msg_feeder_pkg.sv
// Shared constants, state encoding and small helpers for the scrolling-glyph feeder.
package msg_feeder_pkg;

    localparam int         WORD_COUNT = 20;
    localparam int         MSG_LEN    = 20;
    localparam logic [6:0] SHOW_WORD  = 7'h7F;
    localparam logic [6:0] BLANK_WORD = 7'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    // Glyph word for a printable ASCII character 0x20..0x5F.
    function automatic logic [6:0] glyph(input logic [7:0] ascii);
        logic [7:0] offset;
        offset = ascii - 8'h20;
        return {1'b1, offset[5:0]};
    endfunction

    // Terminal count of the half-period divider: H-1 for H = 1, 2, 4, 8.
    function automatic logic [2:0] half_last(input logic [1:0] div_sel);
        logic [2:0] last;
        case (div_sel)
            2'd0:    last = 3'd0;
            2'd1:    last = 3'd1;
            2'd2:    last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational message table: four space-padded texts converted to glyph words.
module msg_rom
    import msg_feeder_pkg::*;
#(
    parameter bit         FORCE_EN  = 1'b0,
    parameter logic [1:0] FORCE_SEL = 2'd0,
    parameter logic [4:0] FORCE_IDX = 5'd0
) (
    input  logic [1:0] msg_sel,
    input  logic [4:0] index,
    output logic [6:0] word
);

    localparam logic [8*MSG_LEN-1:0] MSG0 = "HELLO WORLD         ";
    localparam logic [8*MSG_LEN-1:0] MSG1 = "TINY TAPEOUT 2      ";
    localparam logic [8*MSG_LEN-1:0] MSG2 = "0123456789          ";
    localparam logic [8*MSG_LEN-1:0] MSG3 = "ABCDEFGHIJKLMNOPQRST";

    logic [8*MSG_LEN-1:0] text;
    logic [7:0]           ascii;
    logic [7:0]           bit_pos;

    // Pick the text, extract the character (first character sits in the top byte), encode it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        text    = MSG3;
        ascii   = 8'h20;
        bit_pos = 8'd0;
        case (msg_sel)
            2'd0:    text = MSG0;
            2'd1:    text = MSG1;
            2'd2:    text = MSG2;
            default: text = MSG3;
        endcase
        if (int'(index) < MSG_LEN) begin
            bit_pos = 8'(8 * (MSG_LEN - 1 - int'(index)));
            ascii   = text[bit_pos +: 8];
        end
        word = glyph(ascii);
        // Optional override of one entry to the play command, used to exercise the guard.
        if (FORCE_EN && (msg_sel == FORCE_SEL) && (index == FORCE_IDX)) begin
            word = SHOW_WORD;
        end
    end

endmodule

// File: rtl/msg_feeder.sv
// Feeds a selected message word-by-word into a scrolling-glyph display, then plays it.
module msg_feeder
    import msg_feeder_pkg::*;
#(
    parameter int         WORD_COUNT = msg_feeder_pkg::WORD_COUNT,
    parameter bit         FORCE_EN   = 1'b0,
    parameter logic [1:0] FORCE_SEL  = 2'd0,
    parameter logic [4:0] FORCE_IDX  = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam logic [4:0] LAST_IDX = 5'(WORD_COUNT - 1);

    logic [1:0] msg_sel_in;
    logic [1:0] div_sel_in;
    logic       start_in;
    logic       unused_io;

    assign msg_sel_in = io_in[3:2];
    assign start_in   = io_in[5];
    assign div_sel_in = io_in[7:6];
    // Clock and reset arrive on their own ports; bit 4 carries nothing.
    assign unused_io  = ^{io_in[4], io_in[1:0]};

    state_t     state_q, state_d;
    logic       start_q;
    logic [1:0] sel_q, sel_d;
    logic [1:0] div_q, div_d;
    logic [4:0] idx_q, idx_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] out_q, out_d;

    logic       start_accept;
    logic       phase_done;
    logic [1:0] rom_sel;
    logic [4:0] rom_idx;
    logic [6:0] rom_word;
    logic [6:0] load_word;

    // A rise restarts the load from IDLE or SHOW; a rise during LOAD is dropped.
    assign start_accept = start_in && !start_q && (state_q != LOAD);
    assign phase_done   = (cnt_q == half_last(div_q));

    // The ROM is addressed with the word about to be presented: word 0 on a restart,
    // otherwise the one after the current index.
    assign rom_sel   = start_accept ? msg_sel_in : sel_q;
    assign rom_idx   = start_accept ? 5'd0 : idx_q + 5'd1;
    assign load_word = (rom_word == SHOW_WORD) ? BLANK_WORD : rom_word;

    msg_rom #(
        .FORCE_EN  (FORCE_EN),
        .FORCE_SEL (FORCE_SEL),
        .FORCE_IDX (FORCE_IDX)
    ) u_rom (
        .msg_sel (rom_sel),
        .index   (rom_idx),
        .word    (rom_word)
    );

    // Next-state and next-output logic; disp_din only changes together with disp_clk falling.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        div_d   = div_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (start_accept) begin
            state_d = LOAD;
            sel_d   = msg_sel_in;
            div_d   = div_sel_in;
            idx_d   = 5'd0;
            cnt_d   = 3'd0;
            out_d   = {load_word, 1'b0};
        end else begin
            case (state_q)
                IDLE: begin
                    out_d = 8'h00;
                end
                LOAD: begin
                    if (!phase_done) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                        if (!out_q[0]) begin
                            out_d[0] = 1'b1;
                        end else if (idx_q == LAST_IDX) begin
                            state_d = SHOW;
                            out_d   = {SHOW_WORD, 1'b0};
                        end else begin
                            idx_d = idx_q + 5'd1;
                            out_d = {load_word, 1'b0};
                        end
                    end
                end
                SHOW: begin
                    if (!phase_done) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d    = 3'd0;
                        out_d[0] = ~out_q[0];
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = 8'h00;
                end
            endcase
        end
    end

    // State register with synchronous reset that wins over any simultaneous start rise.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            sel_q   <= 2'd0;
            div_q   <= 2'd0;
            idx_q   <= 5'd0;
            cnt_q   <= 3'd0;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            start_q <= start_in;
            sel_q   <= sel_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign io_out = out_q;

endmodule

// File: tb/tb_msg_feeder.sv
// Self-checking bench for msg_feeder: vector table plus reset / restart corner sequences.
module tb_msg_feeder;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       start   = 1'b0;
    logic [1:0] msg_sel = 2'd0;
    logic [1:0] div_sel = 2'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic [7:0] io_out_f;

    assign io_in = {div_sel, start, 1'b0, msg_sel, rst, clk};

    always #5 clk = ~clk;

    msg_feeder dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out)
    );

    // Same design with "HELLO WORLD" entry 2 forced to the play command.
    msg_feeder #(
        .FORCE_EN  (1'b1),
        .FORCE_SEL (2'd0),
        .FORCE_IDX (5'd2)
    ) dut_f (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out_f)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] exp_q[$];
    logic [6:0] exp_f_q[$];

    typedef struct {
        logic [1:0] sel;
        logic [1:0] div;
        logic [6:0] first;
        int         show_at;
        bit         inject;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoding of the message texts.
    function automatic logic [6:0] exp_word(input int sel, input int k);
        string      s;
        byte        c;
        logic [7:0] off;
        logic [6:0] w;
        case (sel)
            0:       s = "HELLO WORLD";
            1:       s = "TINY TAPEOUT 2";
            2:       s = "0123456789";
            default: s = "ABCDEFGHIJKLMNOPQRST";
        endcase
        c = 8'h20;
        if (k < s.len()) c = s[k];
        off = 8'(c) - 8'h20;
        w = {1'b1, off[5:0]};
        if (w == 7'h7F) w = 7'h40;
        return w;
    endfunction

    // Drive one start rise; returns in the first LOAD cycle.
    task automatic do_start(input logic [1:0] sel, input logic [1:0] div);
        msg_sel = sel;
        div_sel = div;
        start   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_q.push_back(exp_word(int'(sel), k));
            exp_f_q.push_back((sel == 2'd0 && k == 2) ? 7'h40 : exp_word(int'(sel), k));
        end
        tick();
        start = 1'b0;
    endtask

    // Walk one whole LOAD cycle by cycle, then the start of SHOW.
    task automatic walk_load(input string label, input int div, input logic [6:0] first,
                             input int show_at, input bit inject);
        int h;
        int ph;
        int k;
        int errs_clk;
        int errs_din;
        int errs_show;
        logic [6:0] held;
        logic [6:0] w;
        h = 1 << div;
        errs_clk = 0;
        errs_din = 0;
        errs_show = 0;
        held = 7'h00;
        check($sformatf("%s first word", label), {25'd0, io_out[7:1]}, {25'd0, first});
        for (int c = 0; c < show_at; c++) begin
            ph = c % (2 * h);
            k  = c / (2 * h);
            if (inject && c == 5) begin
                start   = 1'b1;
                msg_sel = 2'd3;
                div_sel = 2'd3;
            end
            if (inject && c == 6) start = 1'b0;
            if (io_out[0] !== (ph >= h)) errs_clk++;
            if (ph == 0) held = io_out[7:1];
            else if (io_out[7:1] !== held) errs_din++;
            if (ph == h) begin
                if (exp_q.size() == 0 || exp_f_q.size() == 0) begin
                    check($sformatf("%s queue underflow at word %0d", label, k), 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check($sformatf("%s word %0d", label, k), {25'd0, io_out[7:1]}, {25'd0, w});
                    w = exp_f_q.pop_front();
                    check($sformatf("%s forced-rom word %0d", label, k), {25'd0, io_out_f[7:1]}, {25'd0, w});
                end
            end
            tick();
        end
        check($sformatf("%s clk pattern errors", label), errs_clk, 0);
        check($sformatf("%s din setup errors", label), errs_din, 0);
        check($sformatf("%s words left", label), exp_q.size(), 0);
        check($sformatf("%s show entry", label), {24'd0, io_out}, {24'd0, 7'h7F, 1'b0});
        for (int c = 0; c < 4 * h; c++) begin
            ph = c % (2 * h);
            if (io_out !== {7'h7F, (ph >= h) ? 1'b1 : 1'b0}) errs_show++;
            tick();
        end
        check($sformatf("%s show toggle errors", label), errs_show, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int errs;
        vecs[0] = '{sel: 2'd0, div: 2'd0, first: 7'h68, show_at: 40,  inject: 1'b0};
        vecs[1] = '{sel: 2'd1, div: 2'd1, first: 7'h74, show_at: 80,  inject: 1'b0};
        vecs[2] = '{sel: 2'd2, div: 2'd2, first: 7'h50, show_at: 160, inject: 1'b0};
        vecs[3] = '{sel: 2'd3, div: 2'd3, first: 7'h61, show_at: 320, inject: 1'b0};
        vecs[4] = '{sel: 2'd0, div: 2'd0, first: 7'h68, show_at: 40,  inject: 1'b1};

        // Reset, and reset beating a simultaneous start.
        rst = 1'b1;
        repeat (3) tick();
        check("reset io_out", {24'd0, io_out}, 32'h0);
        start = 1'b1;
        tick();
        check("reset over start", {24'd0, io_out}, 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        errs  = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (io_out !== 8'h00) errs++;
        end
        check("idle quiet", errs, 0);

        // Table: each start comes from IDLE (first) or SHOW (the rest).
        foreach (vecs[i]) begin
            do_start(vecs[i].sel, vecs[i].div);
            walk_load($sformatf("vec%0d", i), int'(vecs[i].div), vecs[i].first,
                      vecs[i].show_at, vecs[i].inject);
        end

        // Reset during word 7 of a load, quiet IDLE, then a clean restart.
        do_start(2'd1, 2'd1);
        repeat (29) tick();
        check("pre-reset word 7", {25'd0, io_out[7:1]}, {25'd0, exp_word(1, 7)});
        rst = 1'b1;
        tick();
        check("mid-load reset io_out", {24'd0, io_out}, 32'h0);
        rst = 1'b0;
        exp_q.delete();
        exp_f_q.delete();
        errs = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (io_out !== 8'h00) errs++;
        end
        check("idle after reset", errs, 0);
        do_start(2'd1, 2'd1);
        walk_load("restart", 1, 7'h74, 80, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
